// File: rtl/gshare_pred_pkg.sv
// Purpose : shared types and index/counter helpers for the gshare predictor bank.
// Latency : n/a (package: types and pure functions only).
// Backpr. : n/a.
// Contents: ctr_t, state_e {ST_INIT, ST_RUN}, fold_hist(), gshare_idx(), sat_update().
package gshare_pred_pkg;

   localparam int DEF_CTR_W = 2;

   typedef logic [DEF_CTR_W-1:0] ctr_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Each hist bit i lands on result bit (i mod idx_w): XOR of successive
   // idx_w-wide slices, with the top slice implicitly zero-padded.
   function automatic logic [31:0] fold_hist(input logic [63:0] hist, input int hist_w,
                                             input int idx_w);
      logic [63:0] h;
      logic [63:0] sl;
      logic [31:0] r;
      logic [31:0] mask;
      h    = (hist_w >= 64) ? hist : (hist & ((64'd1 << hist_w) - 64'd1));
      mask = (idx_w >= 32) ? '1 : ((32'd1 << idx_w) - 32'd1);
      r    = '0;
      for (int s = 0; s < 64; s++) begin
         if (s * idx_w < hist_w) begin
            sl = h >> (s * idx_w);
            r  = r ^ (sl[31:0] & mask);
         end
      end
      return r;
   endfunction

   // pc_trim is pc[IDX_W+1:2] already aligned to bit 0.
   function automatic logic [31:0] gshare_idx(input logic [31:0] pc_trim, input logic [63:0] hist,
                                              input int hist_w, input int idx_w);
      logic [31:0] mask;
      mask = (idx_w >= 32) ? '1 : ((32'd1 << idx_w) - 32'd1);
      return (pc_trim ^ fold_hist(hist, hist_w, idx_w)) & mask;
   endfunction

   function automatic logic [31:0] sat_update(input logic [31:0] ctr, input logic taken,
                                              input int ctr_w);
      logic [31:0] max_v;
      max_v = (32'd1 << ctr_w) - 32'd1;
      if (taken) return (ctr == max_v) ? ctr : ctr + 32'd1;
      else       return (ctr == 32'd0) ? ctr : ctr - 32'd1;
   endfunction

endpackage

// File: rtl/gshare_upd_fifo.sv
// Purpose : generic valid/ready FIFO holding trimmed branch updates.
// Latency : data pushed in cycle N is visible on pop side in cycle N+1 (no bypass).
// Backpr. : push_ready_o is registered (!full after this cycle's push/pop, gated by accept_en_i).
// Ports   : clock/reset_n; accept_en_i (next-cycle permission to accept);
//           push_valid_i/push_ready_o/push_data_i; pop_valid_o/pop_ready_i/pop_data_o.
module gshare_upd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         accept_en_i,
   input  logic         push_valid_i,
   output logic         push_ready_o,
   input  logic [W-1:0] push_data_i,
   output logic         pop_valid_o,
   input  logic         pop_ready_i,
   output logic [W-1:0] pop_data_o
);
   localparam int AW = $clog2(DEPTH);

   // Extra top bit distinguishes full from empty when the low bits match.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         rdy_q;
   logic         push, pop, full_d;
   logic [W-1:0] mem_q [DEPTH];

   assign push_ready_o = rdy_q;
   assign pop_valid_o  = (wr_ptr_q != rd_ptr_q);
   assign pop_data_o   = mem_q[rd_ptr_q[AW-1:0]];
   assign push         = push_valid_i & rdy_q;
   assign pop          = pop_valid_o & pop_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   assign full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= accept_en_i & !full_d;
      end
   end

   // Payload storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/gshare_predictor_bank.sv
// Purpose : multi-port gshare direction predictor with queued counter updates.
// Latency : lookup 1 cycle (req in N -> resp in N+1); update enq N -> counter written N+1 earliest.
// Backpr. : lookups never stall; update_ready is registered (RUN and FIFO not full).
// Ports   : clock, reset_n; req_valid/req_pc/req_hist -> resp_valid/resp_taken per port;
//           update_valid/update_ready/update_pc/update_hist/update_taken; init_done.
// Option  : GSHARE_PRED_PERF_EN adds perf_lookups, perf_updates, perf_flips counters.
module gshare_predictor_bank
   import gshare_pred_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int PC_W      = 64,
   parameter int HIST_W    = 16,
   parameter int IDX_W     = 10,
   parameter int CTR_W     = 2,
   parameter int UPD_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*PC_W-1:0]   req_pc,
   input  logic [NUM_REQ*HIST_W-1:0] req_hist,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [NUM_REQ-1:0]        resp_taken,
   input  logic                      update_valid,
   output logic                      update_ready,
   input  logic [PC_W-1:0]           update_pc,
   input  logic [HIST_W-1:0]         update_hist,
   input  logic                      update_taken,
   output logic                      init_done
`ifdef GSHARE_PRED_PERF_EN
   ,
   output logic [31:0]               perf_lookups,
   output logic [31:0]               perf_updates,
   output logic [31:0]               perf_flips
`endif
);
   localparam int ENTRIES = 1 << IDX_W;
   localparam int UPD_W   = IDX_W + HIST_W + 1;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   logic [NUM_REQ-1:0] resp_valid_q, resp_taken_q;
   logic [IDX_W-1:0]   lk_idx [NUM_REQ];

   logic               tbl_we, deq;
   logic [IDX_W-1:0]   tbl_widx;
   logic [CTR_W-1:0]   tbl_wdat;

   logic               pop_valid;
   logic [UPD_W-1:0]   push_data, pop_data;
   logic [IDX_W-1:0]   upd_idx;
   logic [CTR_W-1:0]   upd_old, upd_new;

   // Only pc[IDX_W+1:2] ever reaches the index, so nothing wider is stored.
   assign push_data = {update_pc[IDX_W+1:2], update_hist, update_taken};

   gshare_upd_fifo #(.W(UPD_W), .DEPTH(UPD_DEPTH)) u_upd_fifo (
      .clock        (clock),
      .reset_n      (reset_n),
      .accept_en_i  (state_d == ST_RUN),
      .push_valid_i (update_valid),
      .push_ready_o (update_ready),
      .push_data_i  (push_data),
      .pop_valid_o  (pop_valid),
      .pop_ready_i  (state_q == ST_RUN),
      .pop_data_o   (pop_data)
   );

   always_comb begin
      upd_idx = IDX_W'(gshare_idx(32'(pop_data[UPD_W-1 -: IDX_W]), 64'(pop_data[HIST_W:1]),
                                  HIST_W, IDX_W));
      upd_old = ctr_q[upd_idx];
      upd_new = CTR_W'(sat_update(32'(upd_old), pop_data[0], CTR_W));
   end

   // FSM: state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
      end
   end

   // FSM: next state. RUN is terminal until reset.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      if (state_q == ST_INIT) begin
         init_ptr_d = init_ptr_q + IDX_W'(1);
         if (&init_ptr_q) state_d = ST_RUN;
      end
   end

   // FSM: outputs. The single table write port is owned by init sweep or dequeue.
   always_comb begin
      tbl_we   = 1'b0;
      tbl_widx = init_ptr_q;
      tbl_wdat = CTR_INIT;
      deq      = 1'b0;
      case (state_q)
         ST_INIT: tbl_we = 1'b1;
         ST_RUN: begin
            if (pop_valid) begin
               deq      = 1'b1;
               tbl_we   = 1'b1;
               tbl_widx = upd_idx;
               tbl_wdat = upd_new;
            end
         end
         default: ;
      endcase
   end

   // Table contents are fully rewritten by the init sweep, so no reset here.
   always_ff @(posedge clock) begin
      if (tbl_we) ctr_q[tbl_widx] <= tbl_wdat;
   end

   always_comb begin
      for (int p = 0; p < NUM_REQ; p++) begin
         lk_idx[p] = IDX_W'(gshare_idx(32'(req_pc[p*PC_W+2 +: IDX_W]),
                                       64'(req_hist[p*HIST_W +: HIST_W]), HIST_W, IDX_W));
      end
   end

   // Reads sample the pre-write table, so a same-cycle update is not forwarded.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         resp_valid_q <= '0;
         resp_taken_q <= '0;
      end else begin
         resp_valid_q <= req_valid;
         for (int p = 0; p < NUM_REQ; p++) begin
            resp_taken_q[p] <= req_valid[p] & (state_q == ST_RUN) & ctr_q[lk_idx[p]][CTR_W-1];
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_taken = resp_taken_q;
   assign init_done  = (state_q == ST_RUN);

`ifdef GSHARE_PRED_PERF_EN
   logic [31:0] perf_lookups_q, perf_updates_q, perf_flips_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_lookups_q <= '0;
         perf_updates_q <= '0;
         perf_flips_q   <= '0;
      end else if (state_q == ST_RUN) begin
         perf_lookups_q <= perf_lookups_q + 32'($countones(req_valid));
         if (deq) begin
            perf_updates_q <= perf_updates_q + 32'd1;
            if (upd_old[CTR_W-1] != upd_new[CTR_W-1]) perf_flips_q <= perf_flips_q + 32'd1;
         end
      end
   end

   assign perf_lookups = perf_lookups_q;
   assign perf_updates = perf_updates_q;
   assign perf_flips   = perf_flips_q;
`endif

endmodule
